// File: rtl/ldm_stm_sequencer.sv
// Load/Store Multiple sequencer: walks the IR register list one register per
// cycle, emitting register number and word address, then reports the
// base writeback value on a one-cycle DONE pulse.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for START with an LDM/STM class instruction
// S_XFER   | outputs show a transfer; advance on each cycle without STALL
// S_FINISH | DONE cycle; WB_EN/WB_VALUE valid, then back to idle
module ldm_stm_sequencer #(
    parameter int ADDR_W = 32,
    parameter int LIST_W = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [31:0]       IR,
    input  logic [ADDR_W-1:0] BASE,
    input  logic              STALL,
    output logic              BUSY,
    output logic              XFER_VALID,
    output logic [3:0]        REG_NUM,
    output logic [ADDR_W-1:0] ADDR,
    output logic              IS_LOAD,
    output logic              LAST,
    output logic              DONE,
    output logic              WB_EN,
    output logic [ADDR_W-1:0] WB_VALUE
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_FINISH} state_t;

    state_t              r_state, w_state_nxt;
    logic [LIST_W-1:0]   r_list, w_list_nxt;
    logic                r_w, w_w_nxt;
    logic                r_is_load, w_is_load_nxt;
    logic [ADDR_W-1:0]   r_wb_value, w_wb_value_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_xfer_valid, w_xfer_valid_nxt;
    logic [3:0]          r_reg_num, w_reg_num_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic                r_last, w_last_nxt;
    logic                r_done, w_done_nxt;
    logic                r_wb_en, w_wb_en_nxt;

    logic [4:0]          w_n;
    logic [ADDR_W-1:0]   w_four_n;
    logic [ADDR_W-1:0]   w_start_addr;
    logic [LIST_W-1:0]   w_list_rest;
    logic [LIST_W-1:0]   w_list_rest2;
    logic                w_accept;
    logic                w_unused;

    function automatic logic [3:0] f_lowest(input logic [LIST_W-1:0] list);
        f_lowest = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (list[i]) f_lowest = i[3:0];
        end
    endfunction

    function automatic logic [4:0] f_count(input logic [LIST_W-1:0] list);
        f_count = '0;
        for (int i = 0; i < LIST_W; i++) begin
            f_count = f_count + {4'b0000, list[i]};
        end
    endfunction

    assign w_unused     = ^{IR[31:28], IR[22], IR[19:16]};
    assign w_accept     = START && (IR[27:25] == 3'b100);
    assign w_n          = f_count(IR[LIST_W-1:0]);
    assign w_four_n     = ADDR_W'({w_n, 2'b00});
    // Lowest register always sits at the lowest address, so every mode
    // reduces to a start address that counts upward.
    assign w_start_addr = (IR[24:23] == 2'b01) ? BASE :
                          (IR[24:23] == 2'b11) ? BASE + ADDR_W'(4) :
                          (IR[24:23] == 2'b00) ? BASE - w_four_n + ADDR_W'(4) :
                                                 BASE - w_four_n;
    assign w_list_rest  = r_list & (r_list - LIST_W'(1));
    assign w_list_rest2 = w_list_rest & (w_list_rest - LIST_W'(1));

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_nxt      = r_state;
        w_list_nxt       = r_list;
        w_w_nxt          = r_w;
        w_is_load_nxt    = r_is_load;
        w_wb_value_nxt   = r_wb_value;
        w_busy_nxt       = r_busy;
        w_xfer_valid_nxt = r_xfer_valid;
        w_reg_num_nxt    = r_reg_num;
        w_addr_nxt       = r_addr;
        w_last_nxt       = r_last;
        w_done_nxt       = 1'b0;
        w_wb_en_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy_nxt       = 1'b0;
                w_xfer_valid_nxt = 1'b0;
                w_reg_num_nxt    = '0;
                w_addr_nxt       = '0;
                w_last_nxt       = 1'b0;
                if (w_accept) begin
                    w_list_nxt     = IR[LIST_W-1:0];
                    w_w_nxt        = IR[21];
                    w_is_load_nxt  = IR[20];
                    w_wb_value_nxt = IR[23] ? BASE + w_four_n : BASE - w_four_n;
                    w_busy_nxt     = 1'b1;
                    if (w_n != 5'd0) begin
                        w_state_nxt      = S_XFER;
                        w_xfer_valid_nxt = 1'b1;
                        w_reg_num_nxt    = f_lowest(IR[LIST_W-1:0]);
                        w_addr_nxt       = w_start_addr;
                        w_last_nxt       = (w_n == 5'd1);
                    end else begin
                        w_state_nxt = S_FINISH;
                        w_done_nxt  = 1'b1;
                        w_wb_en_nxt = IR[21];
                    end
                end
            end
            S_XFER: begin
                if (!STALL) begin
                    w_list_nxt = w_list_rest;
                    if (w_list_rest == '0) begin
                        w_state_nxt      = S_FINISH;
                        w_xfer_valid_nxt = 1'b0;
                        w_reg_num_nxt    = '0;
                        w_addr_nxt       = '0;
                        w_last_nxt       = 1'b0;
                        w_done_nxt       = 1'b1;
                        w_wb_en_nxt      = r_w;
                    end else begin
                        w_reg_num_nxt = f_lowest(w_list_rest);
                        w_addr_nxt    = r_addr + ADDR_W'(4);
                        w_last_nxt    = (w_list_rest2 == '0);
                    end
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_list       <= '0;
            r_w          <= 1'b0;
            r_is_load    <= 1'b0;
            r_wb_value   <= '0;
            r_busy       <= 1'b0;
            r_xfer_valid <= 1'b0;
            r_reg_num    <= '0;
            r_addr       <= '0;
            r_last       <= 1'b0;
            r_done       <= 1'b0;
            r_wb_en      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_list       <= w_list_nxt;
            r_w          <= w_w_nxt;
            r_is_load    <= w_is_load_nxt;
            r_wb_value   <= w_wb_value_nxt;
            r_busy       <= w_busy_nxt;
            r_xfer_valid <= w_xfer_valid_nxt;
            r_reg_num    <= w_reg_num_nxt;
            r_addr       <= w_addr_nxt;
            r_last       <= w_last_nxt;
            r_done       <= w_done_nxt;
            r_wb_en      <= w_wb_en_nxt;
        end
    end

    assign BUSY       = r_busy;
    assign XFER_VALID = r_xfer_valid;
    assign REG_NUM    = r_reg_num;
    assign ADDR       = r_addr;
    assign IS_LOAD    = r_is_load;
    assign LAST       = r_last;
    assign DONE       = r_done;
    assign WB_EN      = r_wb_en;
    assign WB_VALUE   = r_wb_value;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Testbench for ldm_stm_sequencer: directed table of LDM/STM operations,
// reset/ignore corner sequences, and randomized operations against a
// reference model built from the register list and addressing mode.
module tb_ldm_stm_sequencer;

    logic        CLK = 1'b0;
    logic        RESET, START, STALL;
    logic [31:0] IR, BASE;
    logic        BUSY, XFER_VALID, IS_LOAD, LAST, DONE, WB_EN;
    logic [3:0]  REG_NUM;
    logic [31:0] ADDR, WB_VALUE;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ldm_stm_sequencer #(.ADDR_W(32), .LIST_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .IR(IR), .BASE(BASE),
        .STALL(STALL), .BUSY(BUSY), .XFER_VALID(XFER_VALID),
        .REG_NUM(REG_NUM), .ADDR(ADDR), .IS_LOAD(IS_LOAD), .LAST(LAST),
        .DONE(DONE), .WB_EN(WB_EN), .WB_VALUE(WB_VALUE)
    );

    typedef struct {
        logic        p, u, w, l;
        logic [15:0] list;
        logic [31:0] base;
        logic [31:0] stall_mask;
        int          exp_n;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        logic [31:0] exp_wb;
        int          exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // One complete operation; per-cycle expectations come from the model,
    // observed summary values are returned for the directed table.
    task automatic run_op(input logic p, input logic u, input logic w, input logic l,
                          input logic [15:0] list, input logic [31:0] base,
                          input logic [31:0] stall_mask, input bit rnd,
                          output int obs_n, output int obs_done,
                          output logic [31:0] obs_first, output logic [31:0] obs_last,
                          output logic [31:0] obs_wb);
        int          regs[$];
        int          n, idx, c;
        logic [31:0] low, wb, exp_addr;
        logic        st, exp_last;
        regs = {};
        for (int i = 0; i < 16; i++) if (list[i]) regs.push_back(i);
        n   = regs.size();
        low = u ? (p ? base + 32'd4 : base)
                : (p ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4);
        wb  = u ? base + 32'(4 * n) : base - 32'(4 * n);
        obs_n = 0; obs_done = 0; obs_first = '0; obs_last = '0; obs_wb = '0;
        IR    = {4'hE, 3'b100, p, u, 1'b0, w, l, 4'h0, list};
        BASE  = base;
        START = 1'b1;
        STALL = stall_mask[0];
        tick;
        START = 1'b0;
        idx = 0;
        c   = 1;
        while (idx < n) begin
            exp_addr = low + 32'(4 * idx);
            exp_last = (idx == n - 1);
            chk($sformatf("xfer c%0d", c), {XFER_VALID, REG_NUM, ADDR, LAST},
                {1'b1, 4'(regs[idx]), exp_addr, exp_last});
            chk($sformatf("status c%0d", c), {BUSY, DONE, WB_EN, IS_LOAD},
                {1'b1, 1'b0, 1'b0, l});
            if (c == 1 && XFER_VALID) obs_first = ADDR;
            if (XFER_VALID && LAST) obs_last = ADDR;
            st = rnd ? ($urandom_range(3) == 0) : ((c < 32) ? stall_mask[c] : 1'b0);
            STALL = st;
            if (XFER_VALID && !st) obs_n++;
            tick;
            if (!st) idx++;
            c++;
        end
        chk($sformatf("xfer_done c%0d", c), {XFER_VALID, REG_NUM, ADDR, LAST}, '0);
        chk($sformatf("status_done c%0d", c), {BUSY, DONE, WB_EN, IS_LOAD},
            {1'b1, 1'b1, w, l});
        chk("wb_value", WB_VALUE, wb);
        if (DONE) obs_done = c;
        obs_wb = WB_VALUE;
        START = 1'b1;
        STALL = 1'($urandom_range(1));
        tick;
        chk("after_done", {BUSY, DONE, WB_EN, XFER_VALID}, '0);
        START = 1'b0;
        STALL = 1'b0;
        tick;
        chk("idle", {BUSY, DONE, WB_EN, XFER_VALID, REG_NUM, ADDR}, '0);
    endtask

    initial begin
        int          on, od;
        logic [31:0] of, ol, ow;
        logic [15:0] rl;
        logic [31:0] rb;
        int          dummy_n;

        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h000E, 32'h1000, 32'h0, 3, 32'h1000, 32'h1008, 32'h100C, 4};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h8001, 32'h2000, 32'h0, 2, 32'h1FF8, 32'h1FFC, 32'h1FF8, 3};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0030, 32'h0100, 32'h6, 2, 32'h0104, 32'h0108, 32'h0108, 5};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 32'h0040, 32'h0, 0, 32'h0, 32'h0, 32'h0040, 1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 32'hFFFFFFF8, 32'h0, 16, 32'hFFFFFFF8, 32'h34, 32'h38, 17};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0421, 32'h0500, 32'h0, 3, 32'h04F8, 32'h0500, 32'h04F4, 4};

        RESET = 1'b1; START = 1'b0; STALL = 1'b0; IR = '0; BASE = '0;
        tick;
        tick;
        chk("reset_outputs", {BUSY, XFER_VALID, REG_NUM, ADDR, IS_LOAD, LAST, DONE, WB_EN}, '0);
        chk("reset_wb_value", WB_VALUE, '0);
        RESET = 1'b0;
        tick;

        for (int v = 0; v < 6; v++) begin
            run_op(vecs[v].p, vecs[v].u, vecs[v].w, vecs[v].l, vecs[v].list, vecs[v].base,
                   vecs[v].stall_mask, 1'b0, on, od, of, ol, ow);
            chk($sformatf("v%0d count", v), 64'(on), 64'(vecs[v].exp_n));
            chk($sformatf("v%0d done_cycle", v), 64'(od), 64'(vecs[v].exp_done));
            chk($sformatf("v%0d first_addr", v), of, vecs[v].exp_first);
            chk($sformatf("v%0d last_addr", v), ol, vecs[v].exp_last);
            chk($sformatf("v%0d wb_value", v), ow, vecs[v].exp_wb);
        end

        // Wrong instruction class must not start an operation.
        IR = {4'hE, 3'b001, 9'h0A0, 16'h00FF};
        BASE = 32'h3000;
        START = 1'b1;
        tick;
        START = 1'b0;
        chk("bad_class_busy", {BUSY, XFER_VALID, DONE}, '0);
        tick;
        chk("bad_class_idle", {BUSY, XFER_VALID, DONE}, '0);

        // Reset on the second transfer, with START in the same cycle.
        IR = {4'hE, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 16'h000E};
        BASE = 32'h1000;
        START = 1'b1;
        tick;
        START = 1'b0;
        chk("rst_seq_r1", {XFER_VALID, REG_NUM, ADDR}, {1'b1, 4'd1, 32'h1000});
        tick;
        chk("rst_seq_r2", {XFER_VALID, REG_NUM, ADDR}, {1'b1, 4'd2, 32'h1004});
        RESET = 1'b1;
        START = 1'b1;
        tick;
        chk("rst_mid_outputs", {BUSY, XFER_VALID, REG_NUM, ADDR, IS_LOAD, LAST, DONE, WB_EN}, '0);
        chk("rst_mid_wb_value", WB_VALUE, '0);
        RESET = 1'b0;
        START = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk($sformatf("rst_no_done k%0d", k), {BUSY, DONE, XFER_VALID}, '0);
        end

        // Randomized operations with random stalls.
        for (int r = 0; r < 40; r++) begin
            rl = ($urandom_range(3) == 0) ? 16'(1 << $urandom_range(15)) | 16'(1 << $urandom_range(15))
                                          : 16'($urandom);
            if (r % 10 == 0) rl = 16'h0000;
            rb = ($urandom_range(4) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(15)) : $urandom;
            run_op(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                   1'($urandom_range(1)), rl, rb, 32'h0, 1'b1, dummy_n, od, of, ol, ow);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
- Executes Load/Store Multiple (IR[27:25]=100) one register per cycle.
- The shifter only supplies the total block size (4 x register count). This block consumes the register list and produces the per-transfer register number and word address for the register file and memory port.
- Computes the base writeback value and sits between the control unit and the memory interface.

Parameters:
- ADDR_W, 32, width of base and transfer addresses.
- LIST_W, 16, width of the register list (IR[15:0]); fixes REG_NUM width at 4.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request to begin a multiple transfer.
- IR  in  32  instruction word. Fields used: [27:25] class, [24] P, [23] U, [21] W, [20] L, [15:0] register list.
- BASE  in  ADDR_W  base register (Rn) value, sampled with START.
- STALL  in  1  memory not ready; hold the current transfer.
- BUSY  out  1  high from the accepted START through the DONE cycle.
- XFER_VALID  out  1  REG_NUM/ADDR are a valid transfer this cycle.
- REG_NUM  out  4  register being loaded or stored.
- ADDR  out  ADDR_W  word address for this transfer.
- IS_LOAD  out  1  latched IR[20]; 1 = LDM, 0 = STM.
- LAST  out  1  the current transfer is the final one.
- DONE  out  1  one-cycle completion pulse.
- WB_EN  out  1  write WB_VALUE to Rn; valid only while DONE=1.
- WB_VALUE  out  ADDR_W  updated base value.

Behaviour:
- All outputs are registered.
- RESET=1 at any edge, including mid-operation:
  - state goes to IDLE;
  - every output goes to 0;
  - the latched list is cleared;
  - a START in the same cycle is ignored.
- States: IDLE, XFER, FINISH.
- IDLE:
  - START=1 with IR[27:25]=100 is accepted.
  - START is ignored when IR[27:25] differs from 100 or the state is not IDLE.
- On accept:
  - Latch LIST=IR[15:0], P, U, W, L.
  - Compute N = popcount(LIST), range 0..16.
  - Start address S:
    - IA (P=0,U=1): S = BASE
    - IB (P=1,U=1): S = BASE+4
    - DA (P=0,U=0): S = BASE-4N+4
    - DB (P=1,U=0): S = BASE-4N
  - WB_VALUE latched as BASE+4N when U=1, BASE-4N when U=0.
  - All arithmetic is modulo 2^ADDR_W (wrap-around allowed, no flag).
  - BUSY=1 from the next cycle.
  - Next state is XFER if N>0, else FINISH.
- XFER:
  - Registers go out in ascending number order, lowest number at lowest address, for every mode.
  - XFER_VALID=1.
  - REG_NUM = index of the lowest set bit of the remaining list; ADDR = current address.
  - LAST=1 when exactly one bit remains.
  - STALL=1: all outputs and state hold.
  - STALL=0: clear that bit and advance the address by 4. After the LAST transfer, go to FINISH.
- Latency:
  - START at cycle 0 gives the first XFER_VALID at cycle 1.
  - With no stalls, DONE occurs at cycle N+1.
  - Total cycles = N + 1 + stall cycles.
- FINISH (one cycle):
  - DONE=1, XFER_VALID=0.
  - WB_EN = latched W.
  - Return to IDLE; BUSY=0 on the next cycle.
- Empty list (N=0): no transfers; DONE at cycle 1; WB_VALUE = BASE.
- STALL is ignored outside XFER.
- A START on the DONE cycle is ignored; a back-to-back operation needs START in IDLE.
- REG_NUM and ADDR are 0 whenever XFER_VALID=0.
- Base register included in the list: no special handling; the list is transferred as given and writeback happens as specified.

Test Plan:
- IA with W=1 → three transfers, DONE at cycle 4.
  - Stimulus: IR[24:20]=01010, LIST=0x000E, BASE=0x1000, no stall.
  - Transfers: REG_NUM 1/2/3 at ADDR 0x1000/0x1004/0x1008, LAST on the third.
  - DONE at cycle 4 with WB_EN=1, WB_VALUE=0x100C, IS_LOAD=0.
- DB load (P=1, U=0, L=1) → two transfers, no writeback.
  - Stimulus: LIST=0x8001, BASE=0x2000.
  - Transfers: R0 at 0x1FF8, then R15 at 0x1FFC.
  - DONE with WB_VALUE=0x1FF8; WB_EN=0 when W=0.
- STALL during a transfer → outputs hold, then resume.
  - Stimulus: IB, LIST=0x0030, BASE=0x100, STALL=1 during cycles 1-2.
  - R4 @0x104 is held for 3 cycles, then R5 @0x108.
  - DONE at cycle 5.
- Empty list and wrong class → no transfers, START ignored.
  - Stimulus: LIST=0x0000, DA, BASE=0x40.
  - No XFER_VALID; DONE at cycle 1 with WB_VALUE=0x40.
  - START with IR[27:25]=001 leaves BUSY at 0.
- Address wrap-around.
  - Stimulus: IA, LIST=0xFFFF, BASE=0xFFFFFFF8.
  - 16 transfers, addresses wrap 0xFFFFFFF8, 0xFFFFFFFC, 0x0, …
  - WB_VALUE=0x00000038.
- RESET asserted in XFER (second transfer) with START=1 in the same cycle.
  - The next cycle shows all outputs 0 and state IDLE.
  - No DONE pulse follows.
